regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
Read-side companion to the register file's write path. On a Start pulse it walks the register file read port from address 0 to NUM_REGS-1. It presents each word on a valid/ready output stream tagged with its address. Used by the debug/trace path and the test benches to dump architectural state without stalling the write port.

Parameters:
NUM_REGS, 32, number of registers scanned (addresses 0..NUM_REGS-1)
ADDR_WIDTH, 5, register address width; must satisfy 2^ADDR_WIDTH >= NUM_REGS
DATA_WIDTH, 32, register word width

Ports:
Clk  in  1  system clock, all state updates on rising edge
Rst  in  1  synchronous, active-high reset
Start  in  1  begin a dump; sampled only in IDLE
RdAddr  out  ADDR_WIDTH  read address to register file read port
RdData  in  DATA_WIDTH  register file read data, combinational from RdAddr (same cycle)
OutValid  out  1  OutData/OutAddr hold a valid word
OutReady  in  1  consumer accepts word when OutValid && OutReady at rising edge
OutData  out  DATA_WIDTH  dumped register value
OutAddr  out  ADDR_WIDTH  index of OutData
Busy  out  1  high in READ and HOLD
Done  out  1  one-cycle pulse after last word accepted

Behaviour:
- One clock (Clk); reset is synchronous and active-high (Rst); polarity and synchronicity fixed.
- Reset (Rst high at edge, any state): state=IDLE, rd_ptr=0, RdAddr=0, OutValid=0, OutData=0, OutAddr=0, Busy=0, Done=0. Reset mid-dump aborts with no Done pulse.
- RdAddr = rd_ptr (registered counter), never combinational from OutReady.
- States: IDLE, READ, HOLD, DONE.
- IDLE: Start=1 -> READ, rd_ptr=0. Start=0 -> stay.
- READ: OutData<=RdData, OutAddr<=rd_ptr, OutValid<=1, rd_ptr<=rd_ptr+1 -> HOLD.
- HOLD, no handshake (OutValid && !OutReady): OutData, OutAddr and OutValid hold unchanged.
- HOLD, handshake, OutAddr != NUM_REGS-1: load next word the same edge (OutData<=RdData, OutAddr<=rd_ptr), rd_ptr++, OutValid stays 1. Sustained throughput is 1 word/cycle.
- HOLD, handshake, OutAddr == NUM_REGS-1: OutValid<=0, rd_ptr<=0 -> DONE.
- DONE: Done=1 for exactly one cycle -> IDLE. Start in DONE is ignored.
- Start while Busy or Done is ignored; no restart, no queueing.
- Latency: Start sampled at edge E0 -> READ after E0 -> first OutValid=1 after E1. Minimum dump = NUM_REGS+2 cycles from Start to the Done pulse.
- rd_ptr increments past NUM_REGS-1 only to NUM_REGS; that value is never captured. When 2^ADDR_WIDTH == NUM_REGS it wraps to 0 harmlessly.
- No snapshot guarantee: each word is the register file content at its capture edge. Writes during a dump are visible if they precede capture.
- OutData is registered; no combinational path from RdData or OutReady to any output.

Decomposition:
- Shared header regfile_defs.vh holds NUM_REGS, ADDR_WIDTH, DATA_WIDTH defaults and the state encodings (IDLE=2'd0, READ=2'd1, HOLD=2'd2, DONE=2'd3). The register file and this block include the same file.
- One natural sub-module, dump_out_stage: the OutData/OutAddr/OutValid holding register with load/hold/clear controls. The FSM and rd_ptr stay in the top module.

Test Plan:
- Regfile preloaded with reg[i]=32'hA5A5_0000+i, OutReady=1, Start pulse -> 32 consecutive valid cycles, OutAddr 0..31, OutData A5A50000..A5A5001F. Done pulses exactly once, 34 cycles after Start.
- Backpressure: OutReady=0 for 3 cycles while OutAddr=5 -> OutData=A5A50005 and OutValid=1 stable throughout; resuming OutReady=1 gives address 6 next, with no skipped or duplicated index.
- Start re-asserted at OutAddr=10 mid-dump -> ignored, sequence continues to 31, single Done pulse.
- Rst asserted at OutAddr=12 -> next cycle OutValid=0, Busy=0, RdAddr=0, no Done. A fresh Start then dumps from address 0.
- Write reg[20]=32'hDEAD_BEEF while OutAddr=15 (not yet captured) -> word with OutAddr=20 reads DEADBEEF.
- Start held high continuously -> after each Done, IDLE takes Start again and a new dump begins; two full 32-word sequences are observed.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// Shared defaults and FSM state encoding for the register-file dump reader.
// The register file uses the same package.
package regfile_dump_reader_pkg;

  localparam int unsigned NUM_REGS_DEF   = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_dump_reader_out_stage.sv
// Output holding register for the dump stream: load captures a word and sets
// valid, clear drops valid, otherwise the word and its tag are held.
module regfile_dump_reader_out_stage #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0] o_addr
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_addr  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_addr  <= i_addr;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_addr  = r_addr;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks the register file read port from address 0 to NUM_REGS-1 on Start and
// streams each word, tagged with its address, over a valid/ready interface.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  output logic [ADDR_WIDTH-1:0] RdAddr,
  input  logic [DATA_WIDTH-1:0] RdData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_WIDTH-1:0] OutData,
  output logic [ADDR_WIDTH-1:0] OutAddr,
  output logic                  Busy,
  output logic                  Done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic                  r_busy;
  logic                  r_done;

  logic w_hs;
  logic w_last;
  logic w_load;
  logic w_clear;

  assign w_hs    = OutValid && OutReady;
  assign w_last  = (OutAddr == LAST_ADDR);
  // A handshake on a non-final word refills the stage on the same edge,
  // giving one word per cycle under sustained ready.
  assign w_load  = (r_state == ST_READ) || ((r_state == ST_HOLD) && w_hs && !w_last);
  assign w_clear = (r_state == ST_HOLD) && w_hs && w_last;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state  <= ST_IDLE;
      r_rd_ptr <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_state  <= ST_READ;
            r_rd_ptr <= '0;
            r_busy   <= 1'b1;
          end
        end
        ST_READ: begin
          r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
          r_state  <= ST_HOLD;
        end
        ST_HOLD: begin
          if (w_hs) begin
            if (w_last) begin
              r_rd_ptr <= '0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  regfile_dump_reader_out_stage #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_stage (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_data  (RdData),
    .i_addr  (r_rd_ptr),
    .o_valid (OutValid),
    .o_data  (OutData),
    .o_addr  (OutAddr)
  );

  assign RdAddr = r_rd_ptr;
  assign Busy   = r_busy;
  assign Done   = r_done;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full dump, backpressure, ignored
// restart, mid-dump reset, write-before-capture and back-to-back dumps.
module tb_regfile_dump_reader;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Start = 1'b0;
  logic [4:0]  RdAddr;
  logic [31:0] RdData;
  logic        OutValid;
  logic        OutReady = 1'b1;
  logic [31:0] OutData;
  logic [4:0]  OutAddr;
  logic        Busy;
  logic        Done;

  logic [31:0] rf     [32];
  logic [31:0] exp_rf [32];

  int n_cmp  = 0;
  int n_fail = 0;

  int words, dones, done_at;
  logic [31:0] seen20;

  always #5 Clk = ~Clk;

  assign RdData = rf[RdAddr];

  regfile_dump_reader #(
    .NUM_REGS   (32),
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .RdAddr   (RdAddr),
    .RdData   (RdData),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutData  (OutData),
    .OutAddr  (OutAddr),
    .Busy     (Busy),
    .Done     (Done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulses Start (or holds it if hold_start) and follows the stream for
  // max_cyc cycles. Cycle c is sampled after the c-th edge following the
  // edge that sampled Start.
  task automatic run_dump(input int stall_at, input int restart_at, input int write_at,
                          input bit hold_start, input int max_cyc,
                          output int n_words, output int n_done, output int first_done);
    int idx;
    int stall_left;
    idx = 0;
    stall_left = 3;
    n_words = 0;
    n_done = 0;
    first_done = -1;
    @(negedge Clk);
    Start = 1'b1;
    OutReady = 1'b1;
    @(negedge Clk);
    Start = hold_start;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge Clk);
      if (OutValid) begin
        chk("out_addr", {27'd0, OutAddr}, idx);
        chk("out_data", OutData, exp_rf[idx[4:0]]);
        chk("busy_while_valid", {31'd0, Busy}, 32'd1);
        if (OutAddr == 5'd20) seen20 = OutData;
      end
      if (Done) begin
        n_done++;
        if (first_done < 0) first_done = c;
        chk("busy_at_done", {31'd0, Busy}, 32'd0);
        idx = 0;
      end
      OutReady = 1'b1;
      if (stall_at >= 0 && OutValid && OutAddr == stall_at[4:0] && stall_left > 0) begin
        OutReady = 1'b0;
        stall_left--;
      end
      if (OutValid && OutReady) begin
        idx++;
        n_words++;
      end
      Start = hold_start && (c < max_cyc);
      if (restart_at >= 0 && OutValid && OutAddr == restart_at[4:0]) Start = 1'b1;
      if (write_at >= 0 && OutValid && OutAddr == write_at[4:0]) begin
        rf[20] = 32'hDEAD_BEEF;
        exp_rf[20] = 32'hDEAD_BEEF;
      end
    end
    Start = 1'b0;
  endtask

  initial begin
    bit hit;
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'hA5A5_0000 + i;
      exp_rf[i] = 32'hA5A5_0000 + i;
    end
    seen20 = '0;

    repeat (2) @(negedge Clk);
    chk("rst_valid", {31'd0, OutValid}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_rdaddr", {27'd0, RdAddr}, 32'd0);
    chk("rst_outdata", OutData, 32'd0);
    chk("rst_outaddr", {27'd0, OutAddr}, 32'd0);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    chk("idle_valid", {31'd0, OutValid}, 32'd0);

    // Plain dump: 32 words, Done visible 33 edges after the Start edge.
    run_dump(-1, -1, -1, 1'b0, 40, words, dones, done_at);
    chk("t1_words", words, 32);
    chk("t1_dones", dones, 1);
    chk("t1_done_at", done_at, 33);

    // Three stall cycles on address 5 delay Done by three.
    run_dump(5, -1, -1, 1'b0, 42, words, dones, done_at);
    chk("t2_words", words, 32);
    chk("t2_dones", dones, 1);
    chk("t2_done_at", done_at, 36);

    // Start while busy is ignored.
    run_dump(-1, 10, -1, 1'b0, 40, words, dones, done_at);
    chk("t3_words", words, 32);
    chk("t3_dones", dones, 1);
    chk("t3_done_at", done_at, 33);

    // Write to reg 20 while word 15 is presented; later capture sees it.
    run_dump(-1, -1, 15, 1'b0, 40, words, dones, done_at);
    chk("t4_words", words, 32);
    chk("t4_seen20", seen20, 32'hDEAD_BEEF);

    // Reset at address 12 aborts without a Done pulse.
    @(negedge Clk);
    Start = 1'b1;
    OutReady = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge Clk);
      if (OutValid && OutAddr == 5'd12) hit = 1'b1;
    end
    chk("t5_reached12", {31'd0, hit}, 32'd1);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("t5_valid", {31'd0, OutValid}, 32'd0);
    chk("t5_busy", {31'd0, Busy}, 32'd0);
    chk("t5_rdaddr", {27'd0, RdAddr}, 32'd0);
    chk("t5_done", {31'd0, Done}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      chk("t5_no_done", {31'd0, Done}, 32'd0);
      chk("t5_idle_valid", {31'd0, OutValid}, 32'd0);
    end
    run_dump(-1, -1, -1, 1'b0, 40, words, dones, done_at);
    chk("t5_fresh_words", words, 32);
    chk("t5_fresh_dones", dones, 1);

    // Start held high: back-to-back dumps, second Done at cycle 68.
    run_dump(-1, -1, -1, 1'b1, 68, words, dones, done_at);
    chk("t6_words", words, 64);
    chk("t6_dones", dones, 2);
    chk("t6_first_done", done_at, 33);
    repeat (3) @(negedge Clk);
    chk("t6_idle_valid", {31'd0, OutValid}, 32'd0);
    chk("t6_idle_busy", {31'd0, Busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
